// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch: PC, one-outstanding imem handshake, IF/ID register; load is 2 cycles after accept.
// Stalls park a returned word in a one-entry buffer; a redirect flushes IF/ID and discards an in-flight response.
module fetch_stage #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pc_en,
   input  logic        i_if_id_en,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_if_id_inst,
   output logic [31:0] o_if_id_pc,
   output logic [31:0] o_if_id_pc4,
   output logic        o_if_id_valid,
   output logic [6:0]  o_op_code,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2
);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, WAIT, KILL, HOLD} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] fetch_pc;
   logic [31:0] hold_inst;
   logic [31:0] hold_pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc;
   logic        if_id_valid;
   logic        accept;

   // A new fetch may overlap the response that retires the current one.
   assign o_imem_req = ~i_rst & i_pc_en & ~i_redirect &
                       ((state == IDLE) | ((state == WAIT) & i_imem_rvalid & i_if_id_en));
   assign accept     = o_imem_req & i_imem_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= IDLE;
         pc          <= RESET_ADDR;
         if_id_inst  <= NOP;
         if_id_pc    <= 32'h0;
         if_id_valid <= 1'b0;
      end else if (i_redirect) begin
         pc          <= i_redirect_pc & ~32'h3;
         if_id_inst  <= NOP;
         if_id_valid <= 1'b0;
         case (state)
            WAIT:    state <= i_imem_rvalid ? IDLE : KILL;
            KILL:    state <= i_imem_rvalid ? IDLE : KILL;
            default: state <= IDLE;
         endcase
      end else begin
         if (accept) begin
            fetch_pc <= pc;
            pc       <= pc + 32'd4;
         end
         case (state)
            IDLE: begin
               if (accept) state <= WAIT;
               if (i_if_id_en) begin
                  if_id_inst  <= NOP;
                  if_id_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (i_imem_rvalid) begin
                  if (i_if_id_en) begin
                     if_id_inst  <= i_imem_rdata;
                     if_id_pc    <= fetch_pc;
                     if_id_valid <= 1'b1;
                     state       <= accept ? WAIT : IDLE;
                  end else begin
                     hold_inst <= i_imem_rdata;
                     hold_pc   <= fetch_pc;
                     state     <= HOLD;
                  end
               end else if (i_if_id_en) begin
                  if_id_inst  <= NOP;
                  if_id_valid <= 1'b0;
               end
            end
            KILL: begin
               if (i_imem_rvalid) state <= IDLE;
               if (i_if_id_en) begin
                  if_id_inst  <= NOP;
                  if_id_valid <= 1'b0;
               end
            end
            default: begin
               if (i_if_id_en) begin
                  if_id_inst  <= hold_inst;
                  if_id_pc    <= hold_pc;
                  if_id_valid <= 1'b1;
                  state       <= IDLE;
               end
            end
         endcase
      end
   end

   assign o_imem_addr   = pc;
   assign o_if_id_inst  = if_id_inst;
   assign o_if_id_pc    = if_id_pc;
   assign o_if_id_pc4   = if_id_pc + 32'd4;
   assign o_if_id_valid = if_id_valid;
   assign o_op_code     = if_id_inst[6:0];
   assign o_rs1         = if_id_inst[19:15];
   assign o_rs2         = if_id_inst[24:20];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core: owns the PC, issues requests to instruction memory over a valid/ready handshake, and loads the IF/ID pipeline register. It consumes the stall controls produced by the hazard unit (PC_En, IF_ID_En) and redirects from branch/jump resolution. It supplies the decoded fields (opcode, rs1, rs2, valid) that the hazard unit checks, and absorbs memory responses that arrive while the pipeline is stalled or being flushed.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pc_en  in  1  PC_En from hazard unit; 0 blocks issue of new fetches.
- i_if_id_en  in  1  IF_ID_En from hazard unit; 0 holds the IF/ID register.
- i_redirect  in  1  taken branch or jump; flush and refetch.
- i_redirect_pc  in  32  redirect target; bits [1:0] forced to 0 internally.
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  32  fetch address; always equals the PC register.
- i_imem_ready  in  1  memory accepts the request this cycle.
- i_imem_rvalid  in  1  response data valid; at most one request outstanding.
- i_imem_rdata  in  32  instruction word.
- o_if_id_inst  out  32  IF/ID instruction (NOP 32'h0000_0013 when invalid).
- o_if_id_pc  out  32  IF/ID instruction address.
- o_if_id_pc4  out  32  o_if_id_pc + 4, mod 2^32.
- o_if_id_valid  out  1  IF/ID holds a real instruction (valid_inst).
- o_op_code  out  7  o_if_id_inst[6:0].
- o_rs1  out  5  o_if_id_inst[19:15].
- o_rs2  out  5  o_if_id_inst[24:20].

## Operation
- State machine with four states:
  - IDLE: nothing outstanding.
  - WAIT: one request outstanding; its address is held in fetch_pc.
  - KILL: one request outstanding; its response must be discarded.
  - HOLD: a response is parked in a one-entry buffer because IF/ID was stalled.
- Request issue:
  - o_imem_req = i_pc_en & ~i_redirect & (state==IDLE | (state==WAIT & i_imem_rvalid & i_if_id_en)).
  - On acceptance (o_imem_req & i_imem_ready): fetch_pc <= PC, PC <= PC+4 (wraps), next state WAIT.
- WAIT, i_imem_rvalid high:
  - If i_if_id_en: IF/ID <= {rdata, fetch_pc, valid=1}. Next state is WAIT if a new request was accepted this cycle, else IDLE.
  - If ~i_if_id_en: buffer <= {rdata, fetch_pc}, next state HOLD.
- HOLD: when i_if_id_en, IF/ID <= buffer with valid=1, next state IDLE. No request is issued from HOLD.
- KILL: on i_imem_rvalid the data is dropped and next state is IDLE.
- IF/ID load with no instruction available: if i_if_id_en is high and no response or buffer is presented, IF/ID <= bubble (valid=0, inst=NOP, pc unchanged).
- IF/ID hold: if i_if_id_en is low, IF/ID holds its contents.
- Redirect (highest priority, overrides both stall inputs):
  - PC <= {i_redirect_pc[31:2], 2'b00}.
  - IF/ID <= bubble.
  - No request is issued that cycle.
  - WAIT with no rvalid → KILL. WAIT with rvalid → IDLE, data dropped.
  - HOLD → IDLE, buffer dropped. KILL stays KILL unless rvalid. IDLE stays IDLE.
- The buffer and fetch_pc have no reset requirement. Everything else is reset.

## Timing
- Reset values: PC=RESET_ADDR, state=IDLE, o_imem_req=0 during the reset cycle, o_if_id_valid=0, o_if_id_inst=32'h0000_0013, o_if_id_pc=0, o_if_id_pc4=4.
- First request is asserted the cycle after i_rst deasserts, provided i_pc_en=1.
- o_imem_req and o_imem_addr are stable within a cycle. Once asserted, o_imem_req stays asserted with the same address until accepted, unless i_pc_en drops or a redirect arrives.
- Latency: with accept in cycle N and rvalid in cycle N+1, IF/ID is valid in cycle N+2.
- Back-to-back throughput is one instruction per cycle with a 1-cycle memory.
- A response is never lost while stalled: HOLD persists for any number of stall cycles.
- Simultaneous events:
  - Redirect and rvalid in the same cycle: data is dropped.
  - Redirect and stall in the same cycle: flush wins.
  - Reset mid-WAIT: return to IDLE; any later rvalid is ignored (rvalid is only honoured in WAIT/KILL).

## Test plan
- Reset then free-run, 1-cycle memory returning addr-tagged words: fetches 0x0, 0x4, 0x8 on consecutive cycles; o_if_id_valid=1 from cycle 3; o_if_id_pc4=0x8 when o_if_id_pc=0x4.
- i_if_id_en=0 in the cycle rvalid returns word 0x00A00093 at pc 0x10, held low 3 cycles: FSM in HOLD, no req, IF/ID unchanged; on release, IF/ID={0x00A00093, 0x10}, o_rs1=0, o_op_code=0x13.
- Redirect to 0x103 while in WAIT with rvalid delayed 2 cycles: KILL, late data discarded, IF/ID bubble (valid=0, inst=0x13), next request address 0x100.
- i_imem_ready low 4 cycles: o_imem_req and o_imem_addr=0x8 stable; PC does not advance; accepted on cycle 5.
- PC at 0xFFFF_FFFC: o_if_id_pc4=0x0, next fetch address 0x0.
- i_rst asserted in WAIT then stray rvalid: state IDLE, outputs at reset values, IF/ID stays invalid.
